// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb: 8-entry writeback register file with bypassed read ports and a pending-write scoreboard
// Ports:
//   clk, rst (async active-low)
//   read1RegSel/read2RegSel -> read1Data/read2Data (combinational, write bypass), read1Pend/read2Pend
//   issueEn/issueRegSel     : decode marks a destination pending
//   writeEn/writeRegSel/writeData : writeback commit, retires one pending write
//   err                     : sticky scoreboard overflow/underflow/X-control error
module wb_regfile_sb #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1RegSel,
    input  logic [ADDR_W-1:0] read2RegSel,
    output logic [DATA_W-1:0] read1Data,
    output logic [DATA_W-1:0] read2Data,
    output logic              read1Pend,
    output logic              read2Pend,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueRegSel,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] writeRegSel,
    input  logic [DATA_W-1:0] writeData,
    output logic              err
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [DATA_W-1:0] regs    [NREG];
    logic [CNT_W-1:0]  cnt     [NREG];
    logic [CNT_W-1:0]  cnt_nxt [NREG];
    logic [NREG-1:0]   ovf, unf;
    logic              ret1, ret2, x_ctl;

    for (genvar i = 0; i < NREG; i++) begin : g_sb
        logic iss, ret;
        assign iss = issueEn && issueRegSel == ADDR_W'(i);
        assign ret = writeEn && writeRegSel == ADDR_W'(i);
        assign ovf[i] = iss && !ret && cnt[i] == CMAX;
        assign unf[i] = ret && !iss && cnt[i] == '0;
        // saturate at both ends; the offending event only raises err
        assign cnt_nxt[i] = (iss && !ret && !ovf[i]) ? cnt[i] + 1'b1 :
                            (ret && !iss && !unf[i]) ? cnt[i] - 1'b1 : cnt[i];
    end

    // X on the control strobes is only observable in 4-state simulation
    assign x_ctl = $isunknown({writeEn, issueEn});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (writeEn)
                regs[writeRegSel] <= writeData;
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
            err <= err | (|ovf) | (|unf) | x_ctl;
        end
    end

    assign ret1      = writeEn && writeRegSel == read1RegSel;
    assign ret2      = writeEn && writeRegSel == read2RegSel;
    assign read1Data = ret1 ? writeData : regs[read1RegSel];
    assign read2Data = ret2 ? writeData : regs[read2RegSel];
    // a write retiring this cycle is already visible through the bypass
    assign read1Pend = (cnt[read1RegSel] - CNT_W'(ret1)) != '0;
    assign read2Pend = (cnt[read2RegSel] - CNT_W'(ret2)) != '0;
endmodule

// File: tb/tb_wb_regfile_sb.sv
// tb_wb_regfile_sb: directed self-checking bench for wb_regfile_sb
module tb_wb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  read1RegSel, read2RegSel, issueRegSel, writeRegSel;
    logic [15:0] read1Data, read2Data, writeData;
    logic        read1Pend, read2Pend, issueEn, writeEn, err;
    int          passed = 0;
    int          total = 0;

    wb_regfile_sb dut (
        .clk(clk), .rst(rst),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(read1Data), .read2Data(read2Data),
        .read1Pend(read1Pend), .read2Pend(read2Pend),
        .issueEn(issueEn), .issueRegSel(issueRegSel),
        .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
        .err(err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issueEn = 1'b0;
        writeEn = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        for (int s = 0; s < 8; s++) begin
            read1RegSel = 3'(s);
            read2RegSel = 3'(7 - s);
            #1;
            chk("rst_rd1", read1Data, 16'h0000);
            chk("rst_rd2", read2Data, 16'h0000);
            chk("rst_pend", {14'd0, read1Pend, read2Pend}, 16'd0);
            chk("rst_err", {15'd0, err}, 16'd0);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        read1RegSel = '0; read2RegSel = '0; issueRegSel = '0;
        writeRegSel = '0; writeData = '0;
        idle();
        tick();
        rst = 1'b1;
        tick();

        // write R3 with same-cycle bypass on port 2
        writeEn = 1'b1; writeRegSel = 3'd3; writeData = 16'hBEEF;
        read1RegSel = 3'd0; read2RegSel = 3'd3;
        #1;
        chk("bypass_rd2", read2Data, 16'hBEEF);
        chk("nobypass_rd1", read1Data, 16'h0000);
        tick();
        idle();
        read1RegSel = 3'd3;
        #1;
        chk("stored_rd1", read1Data, 16'hBEEF);
        chk("stored_rd2", read2Data, 16'hBEEF);

        // leave some pending state, then reset mid-cycle without a clock edge
        issueEn = 1'b1; issueRegSel = 3'd4;
        tick();
        idle();
        read1RegSel = 3'd4;
        #1;
        chk("pre_rst_pend", {15'd0, read1Pend}, 16'd1);
        reset_pulse();
        tick();

        // scoreboard life cycle on R5
        issueEn = 1'b1; issueRegSel = 3'd5;
        read1RegSel = 3'd5;
        #1;
        chk("issue_not_visible", {15'd0, read1Pend}, 16'd0);
        tick();
        tick();
        idle();
        #1;
        chk("r5_pend2", {15'd0, read1Pend}, 16'd1);
        writeEn = 1'b1; writeRegSel = 3'd5; writeData = 16'h0011;
        #1;
        chk("r5_ret1_pend", {15'd0, read1Pend}, 16'd1);
        tick();
        writeData = 16'h0022;
        #1;
        chk("r5_ret2_pend", {15'd0, read1Pend}, 16'd0);
        chk("r5_ret2_data", read1Data, 16'h0022);
        tick();
        idle();
        #1;
        chk("r5_done_pend", {15'd0, read1Pend}, 16'd0);
        chk("r5_done_data", read1Data, 16'h0022);
        chk("r5_err", {15'd0, err}, 16'd0);

        // simultaneous issue and retire on R2 with cnt=1
        issueEn = 1'b1; issueRegSel = 3'd2;
        tick();
        read2RegSel = 3'd2;
        writeEn = 1'b1; writeRegSel = 3'd2; writeData = 16'h0055;
        #1;
        chk("r2_same_pend", {15'd0, read2Pend}, 16'd0);
        chk("r2_same_data", read2Data, 16'h0055);
        tick();
        idle();
        #1;
        chk("r2_next_pend", {15'd0, read2Pend}, 16'd1);
        chk("r2_err", {15'd0, err}, 16'd0);

        // issue R6 while retiring R2: independent updates
        issueEn = 1'b1; issueRegSel = 3'd6;
        writeEn = 1'b1; writeRegSel = 3'd2; writeData = 16'h0066;
        tick();
        idle();
        read1RegSel = 3'd6;
        #1;
        chk("indep_r6_pend", {15'd0, read1Pend}, 16'd1);
        chk("indep_r2_pend", {15'd0, read2Pend}, 16'd0);
        writeEn = 1'b1; writeRegSel = 3'd6; writeData = 16'h0006;
        tick();
        idle();

        // overflow on R7
        read1RegSel = 3'd7;
        issueEn = 1'b1; issueRegSel = 3'd7;
        for (int k = 0; k < 3; k++) tick();
        #1;
        chk("ovf_err_before", {15'd0, err}, 16'd0);
        tick();
        idle();
        #1;
        chk("ovf_err", {15'd0, err}, 16'd1);
        chk("ovf_pend", {15'd0, read1Pend}, 16'd1);
        writeEn = 1'b1; writeRegSel = 3'd7; writeData = 16'h0777;
        tick();
        tick();
        #1;
        chk("ovf_last_ret_pend", {15'd0, read1Pend}, 16'd0);
        tick();
        idle();
        #1;
        chk("ovf_drained_pend", {15'd0, read1Pend}, 16'd0);
        chk("ovf_err_sticky", {15'd0, err}, 16'd1);
        chk("ovf_data", read1Data, 16'h0777);

        // underflow on R1
        reset_pulse();
        tick();
        writeEn = 1'b1; writeRegSel = 3'd1; writeData = 16'h1234;
        tick();
        idle();
        read1RegSel = 3'd1;
        #1;
        chk("unf_data", read1Data, 16'h1234);
        chk("unf_err", {15'd0, err}, 16'd1);
        chk("unf_pend", {15'd0, read1Pend}, 16'd0);
        tick();
        chk("unf_err_sticky", {15'd0, err}, 16'd1);
        rst = 1'b0;
        #1;
        chk("unf_rst_err", {15'd0, err}, 16'd0);
        chk("unf_rst_data", read1Data, 16'h0000);
        rst = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
